// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Signal bundle between the MIPS pipeline registers and the
//               hazard controller.
//               master modport = pipeline side: drives the ID/EXE hazard
//                                inputs and receives the control outputs.
//               slave  modport = controller side.
//               Inputs  : IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_EXE_MemRead,
//                         ID_EXE_RtReg, BranchTaken, JumpIn, MulDivReq
//               Outputs : PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble,
//                         MulDivBusy, StallCount, FlushCount
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        ID_UsesRt;
  logic        ID_EXE_MemRead;
  logic [4:0]  ID_EXE_RtReg;
  logic        BranchTaken;
  logic        JumpIn;
  logic        MulDivReq;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EXE_Bubble;
  logic        MulDivBusy;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_EXE_MemRead, ID_EXE_RtReg,
           BranchTaken, JumpIn, MulDivReq,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, MulDivBusy,
           StallCount, FlushCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_EXE_MemRead, ID_EXE_RtReg,
           BranchTaken, JumpIn, MulDivReq,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, MulDivBusy,
           StallCount, FlushCount
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard/sequencing controller for a five-stage MIPS pipeline.
//               Resolves load-use stalls, taken-branch and jump flushes and
//               multi-cycle mult/div issue; keeps saturating stall and flush
//               statistics counters.
//               Ports : clk   - pipeline clock (rising edge)
//                       rst_n - asynchronous active-low reset
//                       bus   - pipeline_hazard_ctrl_if.slave (all hazard
//                               inputs, control outputs and counters)
// Parameters  : MULDIV_LAT - stall cycles charged to a mult/div (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [3:0] c_LAT_M1 = 4'(MULDIV_LAT - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_lu;
  logic        w_pcwrite;
  logic        w_ifid_write;
  logic        w_ifid_flush;
  logic        w_bubble;

  // Register 0 is hardwired to zero, so a load to $0 never creates a hazard.
  assign w_lu = bus.ID_EXE_MemRead && (bus.ID_EXE_RtReg != 5'd0) &&
                ((bus.ID_EXE_RtReg == bus.IF_ID_Rs) ||
                 (bus.ID_UsesRt && (bus.ID_EXE_RtReg == bus.IF_ID_Rt)));

  always_comb begin
    w_pcwrite    = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_bubble     = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    if (bus.BranchTaken) begin
      // Wrong-path fetch and decode are both discarded; any mult/div wait
      // is abandoned because that instruction is on the wrong path too.
      w_ifid_flush = 1'b1;
      w_bubble     = 1'b1;
      w_next_state = ST_RUN;
      w_next_cnt   = 4'd0;
    end else if (r_state == ST_WAIT) begin
      if (r_cnt != 4'd0) begin
        w_pcwrite    = 1'b0;
        w_ifid_write = 1'b0;
        w_bubble     = 1'b1;
        w_next_cnt   = r_cnt - 4'd1;
      end else begin
        // Release cycle: mult/div advances into ID/EXE with default controls.
        w_next_state = ST_RUN;
      end
    end else if (w_lu) begin
      // Also takes precedence over a jump, which is re-evaluated next cycle.
      w_pcwrite    = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b1;
    end else if (bus.MulDivReq) begin
      // The entry cycle is itself a stall, so WAIT only covers LAT-1 more.
      w_pcwrite    = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b1;
      w_next_state = ST_WAIT;
      w_next_cnt   = c_LAT_M1;
    end else if (bus.JumpIn) begin
      w_ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!w_pcwrite && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_ifid_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.PCWrite       = w_pcwrite;
  assign bus.IF_ID_Write   = w_ifid_write;
  assign bus.IF_ID_Flush   = w_ifid_flush;
  assign bus.ID_EXE_Bubble = w_bubble;
  assign bus.MulDivBusy    = (r_state == ST_WAIT);
  assign bus.StallCount    = r_stall_cnt;
  assign bus.FlushCount    = r_flush_cnt;

endmodule
`default_nettype wire
